// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle between a BCD source and the multiplexed 7-segment scan driver.
//   bcd_in      packed BCD digits, nibble i = bcd_in[4*i+3:4*i], digit 0 least significant
//   dp_in       decimal point request per digit
//   blank       1: all anodes inactive (scanning continues)
//   an          anode enables, one-hot when lit
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the currently lit digit
//   frame_done  1-cycle pulse at the end of each full scan frame
// Modports: master = digit source / display consumer, slave = scan driver.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0]   dp_in;
  logic                blank;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_done;

  modport master (
    output bcd_in,
    output dp_in,
    output blank,
    input  an,
    input  seg,
    input  dp,
    input  frame_done
  );

  modport slave (
    input  bcd_in,
    input  dp_in,
    input  blank,
    output an,
    output seg,
    output dp,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver for DIGITS packed BCD digits.
// Inputs are snapshotted once per frame so a carry in the upstream counter never tears the
// displayed value.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous, active-high reset
//   bus   seg7_scan_if.slave (bcd_in, dp_in, blank in; an, seg, dp, frame_done out)
// Parameters: DIGITS (2..8), SCAN_DIV (cycles per digit, >=2), ACTIVE_LOW (invert an/seg/dp).
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always
// shown). Without it every digit is always shown.
module seg7_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned PSC_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  // XOR masks that turn active-high values into the output polarity.
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};

  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        shadow_q [DIGITS];
  logic [DIGITS-1:0] shadow_dp_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              frame_done_q;

  logic              tick;
  logic              last;
  logic              snap;
  logic [3:0]        digit;
  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;
  logic              dp_hi;
  logic              show;
  logic [DIGITS-1:0] lz_dark;

  assign tick = (psc_q == PSC_W'(SCAN_DIV - 1));
  assign last = (idx_q == IDX_W'(DIGITS - 1));
  assign snap = tick & last;

  always_comb begin
    psc_d = psc_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      psc_d = '0;
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 goes dark when it and every more significant digit are zero.
  always_comb begin : lz_scan
    logic seen_nz;
    lz_dark = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen_nz    = seen_nz | (shadow_q[i] != 4'd0);
      lz_dark[i] = ~seen_nz;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Active-high decode of the digit currently selected by idx.
  always_comb begin
    digit = shadow_q[idx_q];
    case (digit)
      4'h0:    seg_hi = 7'h3F;
      4'h1:    seg_hi = 7'h06;
      4'h2:    seg_hi = 7'h5B;
      4'h3:    seg_hi = 7'h4F;
      4'h4:    seg_hi = 7'h66;
      4'h5:    seg_hi = 7'h6D;
      4'h6:    seg_hi = 7'h7D;
      4'h7:    seg_hi = 7'h07;
      4'h8:    seg_hi = 7'h7F;
      4'h9:    seg_hi = 7'h6F;
      4'hA:    seg_hi = 7'h40; // dash
      default: seg_hi = 7'h00; // B..F blank
    endcase
  end

  always_comb begin
    show         = ~bus.blank & ~lz_dark[idx_q];
    an_hi        = '0;
    an_hi[idx_q] = show;
    dp_hi        = shadow_dp_q[idx_q] & show;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q        <= '0;
      idx_q        <= '0;
      shadow_dp_q  <= '0;
      frame_done_q <= 1'b0;
      an_q         <= AN_POL;
      seg_q        <= SEG_POL;
      dp_q         <= ACTIVE_LOW;
      for (int i = 0; i < int'(DIGITS); i++) begin
        shadow_q[i] <= 4'd0;
      end
    end else begin
      psc_q        <= psc_d;
      idx_q        <= idx_d;
      frame_done_q <= snap;
      // Outputs follow idx with one cycle of latency so every digit is lit SCAN_DIV cycles.
      an_q         <= an_hi ^ AN_POL;
      seg_q        <= seg_hi ^ SEG_POL;
      dp_q         <= dp_hi ^ ACTIVE_LOW;
      if (snap) begin
        shadow_dp_q <= bus.dp_in;
        for (int i = 0; i < int'(DIGITS); i++) begin
          shadow_q[i] <= bus.bcd_in[4*i +: 4];
        end
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1).
// Table vectors drive one frame of inputs each; the expected 16-cycle frame is queued and
// popped cycle by cycle. Hand sequences cover reset, mid-frame input changes and mid-frame reset.
module tb_seg7_scan_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg7_scan_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS    (4),
    .SCAN_DIV  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpi;
    logic            blk;
    logic [3:0][6:0] seg; // active-low segments expected for digits 3..0
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Steps until frame_done is seen; a bounded wait that counts as a failed check on timeout.
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    if (bus.frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse expected one within 64 cycles");
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [3:0] lit_mask(input logic [15:0] b);
    logic [15:0] hi;
    lit_mask = 4'hF;
    for (int k = 1; k < 4; k++) begin
      hi = b >> (4 * k);
      if (hi == 16'h0) lit_mask[k] = 1'b0;
    end
  endfunction
`endif

  initial begin
    exp_t        e;
    logic [3:0]  lit;
    int          n;

    checks = 0;
    errors = 0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h5678, 4'b0100, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[2] = '{16'h9A0B, 4'b1001, 1'b0, {7'h10, 7'h3F, 7'h40, 7'h7F}};
    vecs[3] = '{16'hCDEF, 4'b1111, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[4] = '{16'h1234, 4'b1111, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[5] = '{16'h0007, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[6] = '{16'h0100, 4'b0000, 1'b0, {7'h40, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{16'h0000, 4'b0001, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};

    rst        = 1'b1;
    bus.bcd_in = 16'h0;
    bus.dp_in  = 4'h0;
    bus.blank  = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_an", 32'(bus.an), 32'hF);
      check("reset_seg", 32'(bus.seg), 32'h7F);
      check("reset_dp", 32'(bus.dp), 32'h1);
      check("reset_fd", 32'(bus.frame_done), 32'h0);
    end

    // First cycle after release lights digit 0 with "0"; first frame_done 16 cycles in.
    rst = 1'b0;
    step();
    check("release_an", 32'(bus.an), 32'hE);
    check("release_seg", 32'(bus.seg), 32'h40);
    check("release_dp", 32'(bus.dp), 32'h1);
    n = 1;
    while (bus.frame_done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("first_frame_len", 32'(n), 32'd16);

    // Table vectors: inputs are snapshotted at the next frame_done and shown in the frame after.
    for (int v = 0; v < 8; v++) begin
      bus.bcd_in = vecs[v].bcd;
      bus.dp_in  = vecs[v].dpi;
      bus.blank  = vecs[v].blk;
      wait_fd();
`ifdef LEADING_ZERO_BLANK_EN
      lit = lit_mask(vecs[v].bcd);
`else
      lit = 4'hF;
`endif
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 4; c++) begin
          e.an  = (vecs[v].blk || !lit[k]) ? 4'hF : (4'hF ^ (4'b0001 << k));
          e.seg = vecs[v].seg[k];
          e.dp  = !(vecs[v].dpi[k] && !vecs[v].blk && lit[k]);
          e.fd  = (k == 3 && c == 3);
          sb.push_back(e);
        end
      end
      for (int s = 0; s < 16; s++) begin
        step();
        e = sb.pop_front();
        check($sformatf("vec%0d_c%0d_an", v, s), 32'(bus.an), 32'(e.an));
        check($sformatf("vec%0d_c%0d_seg", v, s), 32'(bus.seg), 32'(e.seg));
        check($sformatf("vec%0d_c%0d_dp", v, s), 32'(bus.dp), 32'(e.dp));
        check($sformatf("vec%0d_c%0d_fd", v, s), 32'(bus.frame_done), 32'(e.fd));
      end
    end

    // Mid-frame change: 1234 -> 5678 while digit 1 is lit must not tear this frame.
    bus.bcd_in = 16'h1234;
    bus.dp_in  = 4'h0;
    bus.blank  = 1'b0;
    wait_fd();
    for (int i = 0; i < 5; i++) step();
    bus.bcd_in = 16'h5678;
    for (int i = 0; i < 3; i++) step();
    check("tear_d1_an", 32'(bus.an), 32'hD);
    check("tear_d1_seg", 32'(bus.seg), 32'h30);
    for (int i = 0; i < 4; i++) step();
    check("tear_d2_an", 32'(bus.an), 32'hB);
    check("tear_d2_seg", 32'(bus.seg), 32'h24);
    for (int i = 0; i < 4; i++) step();
    check("tear_d3_an", 32'(bus.an), 32'h7);
    check("tear_d3_seg", 32'(bus.seg), 32'h79);
    check("tear_d3_fd", 32'(bus.frame_done), 32'h1);
    step();
    check("new_d0_an", 32'(bus.an), 32'hE);
    check("new_d0_seg", 32'(bus.seg), 32'h00);

    // Reset asserted while digit 2 is lit.
    for (int i = 0; i < 8; i++) step();
    check("pre_rst_an", 32'(bus.an), 32'hB);
    check("pre_rst_seg", 32'(bus.seg), 32'h02);
    rst = 1'b1;
    step();
    check("midrst_an", 32'(bus.an), 32'hF);
    check("midrst_seg", 32'(bus.seg), 32'h7F);
    check("midrst_dp", 32'(bus.dp), 32'h1);
    check("midrst_fd", 32'(bus.frame_done), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_an", 32'(bus.an), 32'hE);
    check("post_rst_seg", 32'(bus.seg), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
